// File: rtl/glitcbus_arbiter.sv
// -----------------------------------------------------------------------------
// glitcbus_arbiter
//
// Shares the single GLITCBUS master port between NUM_REQ WISHBONE-classic
// requesters. Round-robin grant, bus locked to the owner until it drops cyc,
// registered command forwarding, registered ack/data return, and an ack
// timeout so a hung GLITC cannot stall the other requesters.
//
// Optional build macro:
//   GLITCBUS_ARB_STATS_EN - when defined, timeout_count_o counts timeouts
//                           (saturating at 255, cleared only by rst_i);
//                           otherwise timeout_count_o is tied to 0.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_cyc_i/stb_i/we_i  per-requester WISHBONE controls (one bit each)
//   req_adr_i, req_dat_i  packed per-requester address / write data
//   req_dat_o             shared read data, valid with req_ack_o
//   req_ack_o, req_err_o  one-cycle ack / timeout error to the owner
//   grant_o               one-hot current owner, 0 when idle
//   m_*                   master-side WISHBONE to glitcbus_master
//   busy_o                high whenever the arbiter is not idle
//   timeout_count_o       saturating timeout counter (see macro above)
// -----------------------------------------------------------------------------
module glitcbus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADR_WIDTH      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_cyc_i,
    input  logic [NUM_REQ-1:0]           req_stb_i,
    input  logic [NUM_REQ-1:0]           req_we_i,
    input  logic [NUM_REQ*ADR_WIDTH-1:0] req_adr_i,
    input  logic [NUM_REQ*32-1:0]        req_dat_i,
    output logic [31:0]                  req_dat_o,
    output logic [NUM_REQ-1:0]           req_ack_o,
    output logic [NUM_REQ-1:0]           req_err_o,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         m_cyc_o,
    output logic                         m_stb_o,
    output logic                         m_we_o,
    output logic [ADR_WIDTH-1:0]         m_adr_o,
    output logic [31:0]                  m_dat_o,
    input  logic [31:0]                  m_dat_i,
    input  logic                         m_ack_i,
    output logic                         busy_o,
    output logic [7:0]                   timeout_count_o
);

    localparam int unsigned IdxW       = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWaitAck, StAck, StHold} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   m_cyc_q, m_cyc_d;
    logic                   m_stb_q, m_stb_d;
    logic                   m_we_q, m_we_d;
    logic [ADR_WIDTH-1:0]   m_adr_q, m_adr_d;
    logic [31:0]            m_dat_q, m_dat_d;
    logic [31:0]            rdat_q, rdat_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [NUM_REQ-1:0]     err_q, err_d;
    logic                   busy_q, busy_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [NUM_REQ-1:0]     eligible;
    logic                   win_found;
    logic [IdxW-1:0]        win_idx;
    logic [IdxW-1:0]        cand;
    logic [IdxW-1:0]        sel_idx;
    logic                   sel_cyc, sel_stb, sel_we;
    logic [ADR_WIDTH-1:0]   sel_adr;
    logic [31:0]            sel_dat;
    logic [15:0]            cnt_inc;
    logic                   expire;

    assign eligible = req_cyc_i & req_stb_i;
    assign cnt_inc  = cnt_q + 16'd1;
    assign expire   = (cnt_inc == TimeoutVal);

    // Round-robin search: first eligible requester at or after the pointer.
    always_comb begin : rr_search
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IdxW'((32'(ptr_q) + 32'(i)) % NUM_REQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // In IDLE the candidate is the search winner; otherwise the current owner.
    always_comb begin : cmd_mux
        sel_idx = (state_q == StIdle) ? win_idx : owner_q;
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IdxW'(k) == sel_idx) begin
                sel_cyc = req_cyc_i[k];
                sel_stb = req_stb_i[k];
                sel_we  = req_we_i[k];
                sel_adr = req_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
                sel_dat = req_dat_i[k*32 +: 32];
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        m_cyc_d = m_cyc_q;
        m_stb_d = m_stb_q;
        m_we_d  = m_we_q;
        m_adr_d = m_adr_q;
        m_dat_d = m_dat_q;
        rdat_d  = rdat_q;
        ack_d   = '0;
        err_d   = '0;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    m_cyc_d          = 1'b1;
                    m_stb_d          = 1'b1;
                    m_we_d           = sel_we;
                    m_adr_d          = sel_adr;
                    m_dat_d          = sel_dat;
                    cnt_d            = '0;
                    state_d          = StWaitAck;
                end
            end
            StWaitAck: begin
                // An ack in the expiry cycle wins over the timeout.
                if (m_ack_i) begin
                    m_stb_d        = 1'b0;
                    rdat_d         = m_dat_i;
                    ack_d[owner_q] = 1'b1;
                    state_d        = StAck;
                end else if (expire) begin
                    m_stb_d        = 1'b0;
                    m_cyc_d        = 1'b0;
                    err_d[owner_q] = 1'b1;
                    state_d        = StAck;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StAck: begin
                // Owner's stb here is still the strobe that was just acked.
                state_d = StHold;
            end
            StHold: begin
                if (!sel_cyc) begin
                    m_cyc_d = 1'b0;
                    grant_d = '0;
                    ptr_d   = IdxW'((32'(owner_q) + 32'd1) % NUM_REQ);
                    state_d = StIdle;
                end else if (sel_stb) begin
                    m_cyc_d = 1'b1;
                    m_stb_d = 1'b1;
                    m_we_d  = sel_we;
                    m_adr_d = sel_adr;
                    m_dat_d = sel_dat;
                    cnt_d   = '0;
                    state_d = StWaitAck;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_adr_q <= '0;
            m_dat_q <= '0;
            rdat_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            m_cyc_q <= m_cyc_d;
            m_stb_q <= m_stb_d;
            m_we_q  <= m_we_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef GLITCBUS_ARB_STATS_EN
    logic [7:0] tcount_q;
    logic       timeout_evt;

    assign timeout_evt = (state_q == StWaitAck) && !m_ack_i && expire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcount_q <= '0;
        end else if (timeout_evt && (tcount_q != 8'hFF)) begin
            tcount_q <= tcount_q + 8'd1;
        end
    end

    assign timeout_count_o = tcount_q;
`else
    assign timeout_count_o = 8'h00;
`endif

    assign req_dat_o = rdat_q;
    assign req_ack_o = ack_q;
    assign req_err_o = err_q;
    assign grant_o   = grant_q;
    assign m_cyc_o   = m_cyc_q;
    assign m_stb_o   = m_stb_q;
    assign m_we_o    = m_we_q;
    assign m_adr_o   = m_adr_q;
    assign m_dat_o   = m_dat_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_glitcbus_arbiter.sv
// Self-checking bench for glitcbus_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
module tb_glitcbus_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  req_cyc, req_stb, req_we;
    logic [31:0] req_adr;
    logic [63:0] req_dat;
    logic [31:0] req_dat_o;
    logic [1:0]  req_ack_o, req_err_o, grant_o;
    logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i, busy_o;
    logic [15:0] m_adr_o;
    logic [31:0] m_dat_o, m_dat_i;
    logic [7:0]  timeout_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    glitcbus_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (T),
        .ADR_WIDTH      (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_cyc_i       (req_cyc),
        .req_stb_i       (req_stb),
        .req_we_i        (req_we),
        .req_adr_i       (req_adr),
        .req_dat_i       (req_dat),
        .req_dat_o       (req_dat_o),
        .req_ack_o       (req_ack_o),
        .req_err_o       (req_err_o),
        .grant_o         (grant_o),
        .m_cyc_o         (m_cyc_o),
        .m_stb_o         (m_stb_o),
        .m_we_o          (m_we_o),
        .m_adr_o         (m_adr_o),
        .m_dat_o         (m_dat_o),
        .m_dat_i         (m_dat_i),
        .m_ack_i         (m_ack_i),
        .busy_o          (busy_o),
        .timeout_count_o (timeout_count_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_cyc = '0; req_stb = '0; req_we = '0; req_adr = '0; req_dat = '0;
        m_ack_i = 1'b0; m_dat_i = '0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic set_req(input int k, input logic we, input logic [15:0] adr,
                           input logic [31:0] dat);
        req_cyc[k] = 1'b1;
        req_stb[k] = 1'b1;
        req_we[k]  = we;
        req_adr[k*16 +: 16] = adr;
        req_dat[k*32 +: 32] = dat;
    endtask

    task automatic release_req(input int k);
        req_cyc[k] = 1'b0;
        req_stb[k] = 1'b0;
    endtask

    // Slave side: wait for m_stb_o, then ack on the ack_dly-th edge after it
    // rose (0 = never). Reports what the arbiter presented and returned.
    task automatic serve(input int ack_dly, input logic [31:0] rdat,
                         output int stb_wait, output int resp_lat,
                         output logic [1:0] gnt, output logic cyc,
                         output logic we, output logic [15:0] adr,
                         output logic [31:0] dat, output logic [1:0] acks,
                         output logic [1:0] errs, output logic [31:0] rd);
        stb_wait = 0;
        while (m_stb_o !== 1'b1 && stb_wait < 40) begin
            tick();
            stb_wait++;
        end
        gnt = grant_o; cyc = m_cyc_o; we = m_we_o; adr = m_adr_o; dat = m_dat_o;
        resp_lat = 0; acks = '0; errs = '0; rd = '0;
        for (int n = 1; n <= 40; n++) begin
            m_ack_i = (n == ack_dly);
            m_dat_i = (n == ack_dly) ? rdat : $urandom;
            tick();
            if ((req_ack_o | req_err_o) != 2'b00) begin
                acks = req_ack_o; errs = req_err_o; rd = req_dat_o; resp_lat = n;
                break;
            end
        end
        m_ack_i = 1'b0;
    endtask

    int sw, lat;
    logic [1:0] gnt, acks, errs;
    logic cyc, we;
    logic [15:0] adr;
    logic [31:0] dat, rd;

    task automatic test_reset();
        do_reset();
        n_checks++; if (grant_o !== 2'b00) begin n_fail++;
            $display("FAIL reset_grant: got %b expected 00", grant_o); end
        n_checks++; if ({m_cyc_o, m_stb_o, m_we_o, busy_o} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ctl: got %b expected 0000", {m_cyc_o, m_stb_o, m_we_o, busy_o}); end
        n_checks++; if ({m_adr_o, m_dat_o, req_dat_o} !== 80'h0) begin n_fail++;
            $display("FAIL reset_data: got %h expected 0", {m_adr_o, m_dat_o, req_dat_o}); end
        n_checks++; if ({req_ack_o, req_err_o, timeout_count_o} !== 12'h0) begin n_fail++;
            $display("FAIL reset_resp: got %h expected 0", {req_ack_o, req_err_o, timeout_count_o}); end
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(0, 1'b1, 16'h0012, 32'hA5A5A5A5);
        serve(3, 32'h0, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
        n_checks++; if (sw !== 1) begin n_fail++;
            $display("FAIL write_stb_latency: got %0d expected 1", sw); end
        n_checks++; if ({gnt, cyc, we, adr, dat} !== {2'b01, 1'b1, 1'b1, 16'h0012, 32'hA5A5A5A5}) begin
            n_fail++; $display("FAIL write_cmd: got %h expected %h", {gnt, cyc, we, adr, dat},
                               {2'b01, 1'b1, 1'b1, 16'h0012, 32'hA5A5A5A5}); end
        n_checks++; if ({acks, errs} !== 4'b0100 || lat !== 3) begin n_fail++;
            $display("FAIL write_ack: got ack=%b err=%b lat=%0d expected 01/00/3", acks, errs, lat); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++;
            $display("FAIL write_busy: got %b expected 1", busy_o); end
        release_req(0);
        tick();
        n_checks++; if ({req_ack_o, req_err_o} !== 4'b0000) begin n_fail++;
            $display("FAIL write_ack_pulse: got %b expected 0000", {req_ack_o, req_err_o}); end
        tick();
        n_checks++; if ({grant_o, m_cyc_o, busy_o} !== 4'b0000) begin n_fail++;
            $display("FAIL write_release: got %b expected 0000", {grant_o, m_cyc_o, busy_o}); end
    endtask

    task automatic test_read();
        do_reset();
        set_req(1, 1'b0, 16'h0004, 32'h0);
        serve(2, 32'h54495343, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
        n_checks++; if ({gnt, we, adr} !== {2'b10, 1'b0, 16'h0004}) begin n_fail++;
            $display("FAIL read_cmd: got %h expected %h", {gnt, we, adr}, {2'b10, 1'b0, 16'h0004}); end
        n_checks++; if (acks !== 2'b10 || rd !== 32'h54495343) begin n_fail++;
            $display("FAIL read_data: got ack=%b dat=%h expected 10/54495343", acks, rd); end
        release_req(1);
        tick();
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        set_req(0, 1'b1, 16'h0100, 32'h1);
        set_req(1, 1'b1, 16'h0200, 32'h2);
        for (int r = 0; r < 4; r++) begin
            int w;
            w = r % 2;
            serve(2, 32'h0, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
            n_checks++; if (gnt !== 2'(1 << w) || adr !== 16'(16'h0100 * (w + 1))) begin n_fail++;
                $display("FAIL contention_order[%0d]: got grant=%b adr=%h expected owner %0d",
                         r, gnt, adr, w); end
            release_req(w);
            tick();
            tick();
            set_req(w, 1'b1, 16'(16'h0100 * (w + 1)), 32'(w + 1));
        end
        release_req(0);
        release_req(1);
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        set_req(0, 1'b1, 16'h0A00, 32'h0);
        set_req(1, 1'b0, 16'h0B00, 32'h0);
        for (int i = 0; i < 3; i++) begin
            serve(1 + i, 32'h0, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
            n_checks++;
            if (gnt !== 2'b01 || acks !== 2'b01 || adr !== 16'(16'h0A00 + i) ||
                sw !== ((i == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL lock_access[%0d]: got grant=%b ack=%b adr=%h wait=%0d", i, gnt,
                         acks, adr, sw);
            end
            // Keep stb high into the ACK cycle with the next command ready.
            if (i < 2) set_req(0, 1'b1, 16'(16'h0A01 + i), 32'(i));
        end
        release_req(0);
        tick();
        tick();
        serve(2, 32'h0, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
        n_checks++; if (gnt !== 2'b10 || sw !== 1 || adr !== 16'h0B00) begin n_fail++;
            $display("FAIL lock_handover: got grant=%b wait=%0d adr=%h expected 10/1/0b00",
                     gnt, sw, adr); end
        release_req(1);
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic [7:0] exp_tc;
        do_reset();
        set_req(0, 1'b1, 16'h0040, 32'hDEAD0001);
        serve(0, 32'h0, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
        n_checks++; if ({acks, errs} !== 4'b0001 || lat !== T) begin n_fail++;
            $display("FAIL timeout_err: got ack=%b err=%b lat=%0d expected 00/01/%0d",
                     acks, errs, lat, T); end
        n_checks++; if ({m_cyc_o, m_stb_o} !== 2'b00) begin n_fail++;
            $display("FAIL timeout_cyc_drop: got %b expected 00", {m_cyc_o, m_stb_o}); end
`ifdef GLITCBUS_ARB_STATS_EN
        exp_tc = 8'd1;
`else
        exp_tc = 8'd0;
`endif
        n_checks++; if (timeout_count_o !== exp_tc) begin n_fail++;
            $display("FAIL timeout_count: got %0d expected %0d", timeout_count_o, exp_tc); end
        // Still holding cyc: the next strobe re-asserts m_cyc_o; ack at expiry.
        set_req(0, 1'b0, 16'h0044, 32'h0);
        serve(T, 32'h0BADF00D, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
        n_checks++; if (cyc !== 1'b1 || sw !== 2 || adr !== 16'h0044) begin n_fail++;
            $display("FAIL timeout_recyc: got cyc=%b wait=%0d adr=%h expected 1/2/0044",
                     cyc, sw, adr); end
        n_checks++; if ({acks, errs} !== 4'b0100 || lat !== T || rd !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL expiry_ack: got ack=%b err=%b lat=%0d dat=%h", acks, errs,
                               lat, rd); end
        n_checks++; if (timeout_count_o !== exp_tc) begin n_fail++;
            $display("FAIL expiry_count: got %0d expected %0d", timeout_count_o, exp_tc); end
        release_req(0);
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 1'b1, 16'h0001, 32'h0);
        serve(1, 32'h0, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
        release_req(0);
        tick();
        tick();
        set_req(1, 1'b1, 16'h0002, 32'h0);
        tick();
        n_checks++; if ({m_stb_o, grant_o} !== 3'b110) begin n_fail++;
            $display("FAIL midreset_setup: got %b expected 110", {m_stb_o, grant_o}); end
        rst_i = 1'b1;
        tick();
        n_checks++;
        if ({grant_o, m_cyc_o, m_stb_o, m_we_o, busy_o, req_ack_o, req_err_o} !== 10'h0 ||
            {m_adr_o, m_dat_o, req_dat_o} !== 80'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got grant=%b cyc=%b stb=%b ack=%b err=%b adr=%h",
                     grant_o, m_cyc_o, m_stb_o, req_ack_o, req_err_o, m_adr_o);
        end
        rst_i = 1'b0;
        set_req(0, 1'b1, 16'h0003, 32'h0);
        serve(1, 32'h0, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
        n_checks++; if (gnt !== 2'b01 || sw !== 1 || acks !== 2'b01) begin n_fail++;
            $display("FAIL midreset_regrant: got grant=%b wait=%0d ack=%b expected 01/1/01",
                     gnt, sw, acks); end
        release_req(0);
        release_req(1);
        tick();
        tick();
    endtask

    // Randomised rounds against a round-robin / response model.
    task automatic test_random();
        int model_ptr, model_to, w, d, exp_lat;
        logic [1:0]  mask, pend;
        logic        e_we[2];
        logic [15:0] e_adr[2];
        logic [31:0] e_dat[2];
        logic [31:0] rdat;
        logic        exp_ack;
        logic [7:0]  exp_tc;
        do_reset();
        model_ptr = 0;
        model_to  = 0;
        for (int r = 0; r < 25; r++) begin
            mask = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                if (mask[k]) begin
                    e_we[k] = 1'($urandom); e_adr[k] = 16'($urandom); e_dat[k] = $urandom;
                    set_req(k, e_we[k], e_adr[k], e_dat[k]);
                end
            end
            pend = mask;
            while (pend != 2'b00) begin
                w = pend[model_ptr] ? model_ptr : 1 - model_ptr;
                d = $urandom_range(0, T + 3);
                rdat = $urandom;
                exp_ack = (d >= 1 && d <= T);
                exp_lat = exp_ack ? d : T;
                serve(d, rdat, sw, lat, gnt, cyc, we, adr, dat, acks, errs, rd);
                n_checks++;
                if (gnt !== 2'(1 << w) || sw !== 1 || {we, adr, dat} !== {e_we[w], e_adr[w], e_dat[w]})
                begin
                    n_fail++;
                    $display("FAIL rand_cmd[%0d]: got grant=%b wait=%0d cmd=%h expected owner %0d cmd=%h",
                             r, gnt, sw, {we, adr, dat}, w, {e_we[w], e_adr[w], e_dat[w]});
                end
                n_checks++;
                if (acks !== (exp_ack ? 2'(1 << w) : 2'b00) ||
                    errs !== (exp_ack ? 2'b00 : 2'(1 << w)) || lat !== exp_lat ||
                    (exp_ack && rd !== rdat)) begin
                    n_fail++;
                    $display("FAIL rand_resp[%0d]: got ack=%b err=%b lat=%0d dat=%h dly=%0d",
                             r, acks, errs, lat, rd, d);
                end
                if (!exp_ack && model_to < 255) model_to++;
                release_req(w);
                tick();
                tick();
                pend[w] = 1'b0;
                model_ptr = (w + 1) % 2;
            end
        end
`ifdef GLITCBUS_ARB_STATS_EN
        exp_tc = 8'(model_to);
`else
        exp_tc = 8'd0;
`endif
        n_checks++; if (timeout_count_o !== exp_tc) begin n_fail++;
            $display("FAIL rand_timeout_count: got %0d expected %0d", timeout_count_o, exp_tc); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
